// File: rtl/counter_monitor.sv
// Passive reference-model checker for a loadable up-counter; flags and counts divergence and wraps.
// All outputs registered: a mismatch seen in cycle n is reported in cycle n+1.
module counter_monitor #(
    parameter int DATA_WIDTH    = 4,
    parameter int COUNT_START   = 0,
    parameter int COUNT_END     = 2 ** (DATA_WIDTH - 1),
    parameter int STEP          = 1,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     load,
    input  logic [DATA_WIDTH-1:0]    loadval,
    input  logic [DATA_WIDTH-1:0]    dataIn,
    input  logic                     clrCount,
    output logic [DATA_WIDTH-1:0]    expected,
    output logic                     locked,
    output logic                     err,
    output logic [ERR_CNT_WIDTH-1:0] errCount,
    output logic                     wrapPulse,
    output logic [ERR_CNT_WIDTH-1:0] wrapCount
);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0]    C_START   = DATA_WIDTH'(COUNT_START);
    localparam logic [DATA_WIDTH-1:0]    C_END     = DATA_WIDTH'(COUNT_END);
    localparam logic [DATA_WIDTH-1:0]    C_STEP    = DATA_WIDTH'(STEP);
    localparam logic [ERR_CNT_WIDTH-1:0] C_CNT_MAX = '1;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_expected;
    logic                    r_locked;
    logic                    r_err;
    logic                    r_wrap;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
    logic [ERR_CNT_WIDTH-1:0] r_wrap_cnt;

    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   w_expected_nxt;
    logic                    w_err_nxt;
    logic                    w_wrap_nxt;
    logic                    w_match;

    // Load wins over enable; values above the wrap point simply roll over the register width.
    function automatic logic [DATA_WIDTH-1:0] f_nxt(
        input logic [DATA_WIDTH-1:0] v,
        input logic                  ld,
        input logic                  e,
        input logic [DATA_WIDTH-1:0] lv
    );
        if (ld)
            return lv;
        else if (e && (v == C_END))
            return C_START;
        else if (e)
            return v + C_STEP;
        else
            return v;
    endfunction

    function automatic logic f_wrap(
        input logic [DATA_WIDTH-1:0] v,
        input logic                  ld,
        input logic                  e
    );
        return !ld && e && (v == C_END);
    endfunction

    function automatic logic [ERR_CNT_WIDTH-1:0] f_cnt(
        input logic [ERR_CNT_WIDTH-1:0] cnt,
        input logic                     inc,
        input logic                     clr
    );
        if (clr)
            return inc ? ERR_CNT_WIDTH'(1) : '0;
        else if (inc && (cnt != C_CNT_MAX))
            return cnt + ERR_CNT_WIDTH'(1);
        else
            return cnt;
    endfunction

    assign w_match = (dataIn == r_expected);

    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_err_nxt      = 1'b0;
        w_wrap_nxt     = 1'b0;
        case (r_state)
            SYNC: begin
                w_expected_nxt = f_nxt(dataIn, load, en, loadval);
                w_state_nxt    = TRACK;
            end
            default: begin
                if (w_match) begin
                    w_expected_nxt = f_nxt(r_expected, load, en, loadval);
                    w_wrap_nxt     = f_wrap(r_expected, load, en);
                    w_state_nxt    = TRACK;
                end else begin
                    // Re-anchor on the observed value so a single glitch costs one error, not a stream.
                    w_err_nxt      = 1'b1;
                    w_expected_nxt = f_nxt(dataIn, load, en, loadval);
                    w_state_nxt    = RESYNC;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= SYNC;
            r_expected <= C_START;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_wrap     <= 1'b0;
            r_err_cnt  <= '0;
            r_wrap_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_expected <= w_expected_nxt;
            r_locked   <= (w_state_nxt == TRACK);
            r_err      <= w_err_nxt;
            r_wrap     <= w_wrap_nxt;
            r_err_cnt  <= f_cnt(r_err_cnt, w_err_nxt, clrCount);
            r_wrap_cnt <= f_cnt(r_wrap_cnt, w_wrap_nxt, clrCount);
        end
    end

    assign expected  = r_expected;
    assign locked    = r_locked;
    assign err       = r_err;
    assign wrapPulse = r_wrap;
    assign errCount  = r_err_cnt;
    assign wrapCount = r_wrap_cnt;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: two instances (8-bit and 2-bit counters) fed identical stimulus.
module tb_counter_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] loadval;
    logic [3:0] dataIn;
    logic       clrCount;

    logic [3:0] exp_a, exp_b;
    logic       lck_a, lck_b, err_a, err_b, wp_a, wp_b;
    logic [7:0] ec_a, wc_a;
    logic [1:0] ec_b, wc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_monitor u_dut_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .loadval(loadval),
        .dataIn(dataIn), .clrCount(clrCount), .expected(exp_a), .locked(lck_a),
        .err(err_a), .errCount(ec_a), .wrapPulse(wp_a), .wrapCount(wc_a)
    );

    counter_monitor #(.ERR_CNT_WIDTH(2)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .load(load), .loadval(loadval),
        .dataIn(dataIn), .clrCount(clrCount), .expected(exp_b), .locked(lck_b),
        .err(err_b), .errCount(ec_b), .wrapPulse(wp_b), .wrapCount(wc_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    task automatic chk_st(input string tag, input int e_exp, input int e_lck,
                          input int e_err, input int e_wp);
        chk({tag, ".expected"},  32'(exp_a), 32'(e_exp));
        chk({tag, ".locked"},    32'(lck_a), 32'(e_lck));
        chk({tag, ".err"},       32'(err_a), 32'(e_err));
        chk({tag, ".wrapPulse"}, 32'(wp_a),  32'(e_wp));
        chk({tag, ".expected_b"}, 32'(exp_b), 32'(e_exp));
        chk({tag, ".err_b"},      32'(err_b), 32'(e_err));
    endtask

    task automatic chk_cnt(input string tag, input int e_ec_a, input int e_ec_b, input int e_wc);
        chk({tag, ".errCount"},    32'(ec_a), 32'(e_ec_a));
        chk({tag, ".errCount_b"},  32'(ec_b), 32'(e_ec_b));
        chk({tag, ".wrapCount"},   32'(wc_a), 32'(e_wc));
        chk({tag, ".wrapCount_b"}, 32'(wc_b), 32'(e_wc));
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; load = 1'b0; loadval = 4'd0; dataIn = 4'd0; clrCount = 1'b0;

        // Reset state
        tick();
        chk_st("reset", 0, 0, 0, 0);
        chk_cnt("reset", 0, 0, 0);

        // Conforming count 0..8,0,1,2 with one wrap
        rst = 1'b1; en = 1'b1; dataIn = 4'd0;
        tick();
        chk_st("sync_edge", 1, 1, 0, 0);
        for (int v = 1; v <= 8; v++) begin
            dataIn = 4'(v);
            tick();
            chk_st($sformatf("count_%0d", v), (v == 8) ? 0 : v + 1, 1, 0, (v == 8) ? 1 : 0);
        end
        dataIn = 4'd0; tick();
        chk_st("after_wrap", 1, 1, 0, 0);
        chk_cnt("after_wrap", 0, 0, 1);
        dataIn = 4'd1; tick();
        chk_st("count_1b", 2, 1, 0, 0);
        dataIn = 4'd2; tick();
        chk_st("count_2b", 3, 1, 0, 0);

        // Load while at 3
        dataIn = 4'd3; load = 1'b1; loadval = 4'd4; tick();
        chk_st("load_4", 4, 1, 0, 0);
        load = 1'b0; dataIn = 4'd4; tick();
        chk_st("after_load", 5, 1, 0, 0);

        // Fault injection: 7 instead of 5, then 8,0
        dataIn = 4'd7; tick();
        chk_st("fault_7", 8, 0, 1, 0);
        chk_cnt("fault_7", 1, 1, 1);
        dataIn = 4'd8; tick();
        chk_st("relock_8", 0, 1, 0, 1);
        chk_cnt("relock_8", 1, 1, 2);
        dataIn = 4'd0; tick();
        chk_st("relock_0", 1, 1, 0, 0);

        // Advance to 6, then hold with en=0
        for (int v = 1; v <= 5; v++) begin
            dataIn = 4'(v);
            tick();
        end
        chk_st("at_6", 6, 1, 0, 0);
        en = 1'b0; dataIn = 4'd6;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_st($sformatf("hold_%0d", i), 6, 1, 0, 0);
        end
        dataIn = 4'd2; tick();
        chk_st("hold_jump", 2, 0, 1, 0);
        chk_cnt("hold_jump", 2, 2, 2);
        tick();
        chk_st("hold_relock", 2, 1, 0, 0);

        // Mid-operation reset while locked with errCount=2
        rst = 1'b0; dataIn = 4'd9; en = 1'b1; tick();
        chk_st("mid_reset", 0, 0, 0, 0);
        chk_cnt("mid_reset", 0, 0, 0);
        rst = 1'b1; dataIn = 4'd5; tick();
        chk_st("post_reset", 6, 1, 0, 0);

        // Five consecutive mismatches: 2-bit counter saturates at 3
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dataIn = 4'(i);
            tick();
            chk_st($sformatf("burst_%0d", i), i, 0, 1, 0);
            chk_cnt($sformatf("burst_%0d", i), i + 1, (i >= 2) ? 3 : i + 1, 0);
        end

        // Clear with no error, then clear coinciding with an error
        clrCount = 1'b1; dataIn = 4'd4; tick();
        chk_st("clr_quiet", 4, 1, 0, 0);
        chk_cnt("clr_quiet", 0, 0, 0);
        dataIn = 4'd9; tick();
        chk_st("clr_err", 9, 0, 1, 0);
        chk_cnt("clr_err", 1, 1, 0);

        // Clear coinciding with a wrap loads wrapCount with 1
        clrCount = 1'b0; load = 1'b1; loadval = 4'd8; tick();
        chk_st("load_8", 8, 1, 0, 0);
        load = 1'b0; en = 1'b1; dataIn = 4'd8; clrCount = 1'b1; tick();
        chk_st("clr_wrap", 0, 1, 0, 1);
        chk_cnt("clr_wrap", 0, 0, 1);

        // Above the wrap point: 14 -> 15 -> 0 is a rollover, not a wrap
        clrCount = 1'b0; load = 1'b1; loadval = 4'd14; dataIn = 4'd0; tick();
        chk_st("load_14", 14, 1, 0, 0);
        load = 1'b0; dataIn = 4'd14; tick();
        chk_st("roll_14", 15, 1, 0, 0);
        dataIn = 4'd15; tick();
        chk_st("roll_15", 0, 1, 0, 0);
        chk_cnt("roll_end", 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
- Passive checker that sits beside a loadable up-counter and observes its clock-domain signals (en, load, loadval, count value).
- Runs a reference model of the counter and flags every cycle where the observed value departs from the model.
- Counts errors and wrap events, and reports lock status.
- Used in simulation benches and as an on-chip health monitor; it never drives the counter.

Parameters:
DATA_WIDTH, 4, width of observed count value and loadval
COUNT_START, 0, value the counter wraps to
COUNT_END, 2**(DATA_WIDTH-1), value after which the counter wraps
STEP, 1, increment per enabled cycle
ERR_CNT_WIDTH, 8, width of errCount and wrapCount

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-low
en  input  1  observed counter enable
load  input  1  observed counter load strobe
loadval  input  DATA_WIDTH  observed load value
dataIn  input  DATA_WIDTH  observed counter output
clrCount  input  1  synchronous clear of errCount and wrapCount
expected  output  DATA_WIDTH  model value for the current cycle
locked  output  1  model agrees with the counter
err  output  1  one-cycle mismatch pulse
errCount  output  ERR_CNT_WIDTH  saturating mismatch count
wrapPulse  output  1  one-cycle pulse on a verified wrap
wrapCount  output  ERR_CNT_WIDTH  saturating wrap count

Behaviour:
- Reset: rst=0 at a rising edge sets:
  - state=SYNC, expected=COUNT_START, locked=0, err=0, wrapPulse=0, errCount=0, wrapCount=0.
  - Reset takes priority over every other input.
- Model next-value function nxt(v):
  - load=1 -> loadval. Load has priority over en.
  - else en=1 and v==COUNT_END -> COUNT_START. This is the wrap branch.
  - else en=1 -> (v+STEP) mod 2**DATA_WIDTH. No saturation.
  - else -> v.
- Values above COUNT_END, e.g. from a load, increment and roll over at 2**DATA_WIDTH. They are not errors in themselves.
- dataIn is the counter register value before the edge. en, load and loadval are sampled at the same edge as the counter samples them.
- FSM states:
  - SYNC (locked=0):
    - Edge: expected<=nxt(dataIn), then go to TRACK.
    - No comparison and no err in SYNC.
  - TRACK (locked=1):
    - Edge, dataIn==expected: expected<=nxt(expected). If the wrap branch was taken, wrapPulse<=1.
    - Edge, mismatch: err<=1, expected<=nxt(dataIn), go to RESYNC.
  - RESYNC (locked=0):
    - Edge, dataIn==expected: expected<=nxt(expected), go to TRACK. A wrap here also pulses wrapPulse.
    - Edge, mismatch: err<=1, expected<=nxt(dataIn), stay in RESYNC.
- locked is a registered decode of the state and changes on the same edge as the state.
- Latency: a mismatch on dataIn during cycle n gives err=1 during cycle n+1 only. err and wrapPulse are single-cycle pulses and are never set together.
- errCount increments on every err and holds at all-ones. wrapCount increments on every wrapPulse and holds at all-ones.
- clrCount=1 clears both counters to 0. If an increment event occurs in the same cycle, that counter loads 1 instead of 0.
- Mid-operation reset returns to SYNC. The first edge after rst deasserts adopts dataIn, whatever its value.
- All outputs are registered. There are no combinational input-to-output paths.

Test Plan:
Bench settings: DATA_WIDTH=4, START=0, END=8, STEP=1 unless noted.
1. Reset, then a conforming counter with en=1 producing 0,1,…,8,0,1 -> locked=1 from the second edge, err never asserted, exactly one wrapPulse (one cycle after dataIn=8 is sampled), wrapCount=1, errCount=0.
2. While at 3, load=1 with loadval=4h4 for one cycle, en=1; counter goes 3,4,5 -> no err, expected tracks 4,5.
3. Fault injection: expected=5 but force dataIn=7 for one cycle, then 8,0 -> err high for exactly one cycle, errCount=1, locked=0 for one cycle, then locked=1 with no further err. The wrap from 8 still pulses wrapPulse.
4. en=0 for 10 cycles with dataIn held at 6 -> no err. Change dataIn to 2 while en=0 -> one err pulse, errCount increments.
5. ERR_CNT_WIDTH=2, five consecutive mismatches -> err asserted five cycles, state stays RESYNC, errCount=3 (saturated). clrCount=1 in a cycle with no error -> errCount=0. clrCount=1 in the same cycle as an err -> errCount=1.
6. Reset while locked with errCount=2: rst=0 for one edge -> all outputs return to reset values. First edge after release with dataIn=5 and en=1 -> expected=6, locked=1, no err.
